// File: rtl/rv_enc_pkg.sv
// rtl/rv_enc_pkg.sv - Shared op codes, RV32I field constants and format packers for instr_encoder
package rv_enc_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_XOR  = 4'd2,
    OP_ADDI = 4'd3,
    OP_ORI  = 4'd4,
    OP_SRAI = 4'd5,
    OP_LB   = 4'd6,
    OP_LW   = 4'd7,
    OP_SB   = 4'd8,
    OP_SW   = 4'd9,
    OP_LUI  = 4'd10,
    OP_LI   = 4'd11
  } op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_SRA = 3'b101;
  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_W   = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SRA  = 7'b0100000;

  typedef enum logic {S_IDLE, S_LI_LO} state_e;

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] opc);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] u_type(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// rtl/enc_fifo.sv - Synchronous word FIFO; reads back zero while empty.
module enc_fifo
  import rv_enc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the empty flag masks stale entries.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I encoder: packs symbolic requests into words, expands LI, tags pc.
module instr_encoder
  import rv_enc_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        err
);

  state_e      state_q;
  logic [4:0]  li_rd_q;
  logic [11:0] li_lo_q;
  logic        err_q;
  logic [31:0] pc_q, pc_d;

  op_e         op;
  logic [31:0] enc_word;
  logic        enc_ok, enc_li2;
  logic        i_fits;
  logic [19:0] li_hi;
  logic [11:0] imm12;

  logic        fifo_full, fifo_empty, accept, push, pop;
  logic [31:0] push_word;

  assign op     = op_e'(req_op);
  assign imm12  = req_imm[11:0];
  assign i_fits = (req_imm[31:11] == '0) || (req_imm[31:11] == '1);
  // Adding 0x800 before the shift only ever carries into bit 12 via imm[11].
  assign li_hi  = req_imm[31:12] + {19'd0, req_imm[11]};

  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b1;
    enc_li2  = 1'b0;
    case (op)
      OP_NOP:  enc_word = '0;
      OP_ADD:  enc_word = r_type(F7_BASE, req_rs2, req_rs1, F3_ADD, req_rd, OPC_OP);
      OP_XOR:  enc_word = r_type(F7_BASE, req_rs2, req_rs1, F3_XOR, req_rd, OPC_OP);
      OP_ADDI: begin
        enc_ok   = i_fits;
        enc_word = i_type(imm12, req_rs1, F3_ADD, req_rd, OPC_OP_IMM);
      end
      OP_ORI: begin
        enc_ok   = i_fits;
        enc_word = i_type(imm12, req_rs1, F3_OR, req_rd, OPC_OP_IMM);
      end
      OP_SRAI: begin
        enc_ok   = (req_imm[31:5] == '0);
        enc_word = i_type({F7_SRA, req_imm[4:0]}, req_rs1, F3_SRA, req_rd, OPC_OP_IMM);
      end
      OP_LB: begin
        enc_ok   = i_fits;
        enc_word = i_type(imm12, req_rs1, F3_B, req_rd, OPC_LOAD);
      end
      OP_LW: begin
        enc_ok   = i_fits;
        enc_word = i_type(imm12, req_rs1, F3_W, req_rd, OPC_LOAD);
      end
      OP_SB: begin
        enc_ok   = i_fits;
        enc_word = s_type(imm12, req_rs2, req_rs1, F3_B, OPC_STORE);
      end
      OP_SW: begin
        enc_ok   = i_fits;
        enc_word = s_type(imm12, req_rs2, req_rs1, F3_W, OPC_STORE);
      end
      OP_LUI: begin
        enc_ok   = (imm12 == '0);
        enc_word = u_type(req_imm[31:12], req_rd, OPC_LUI);
      end
      OP_LI: begin
        if (i_fits) begin
          enc_word = i_type(imm12, 5'd0, F3_ADD, req_rd, OPC_OP_IMM);
        end else begin
          enc_word = u_type(li_hi, req_rd, OPC_LUI);
          enc_li2  = (imm12 != '0);
        end
      end
      default: enc_ok = 1'b0;
    endcase
  end

  assign req_ready = (state_q == S_IDLE) && !fifo_full;
  assign accept    = req_valid && req_ready;
  assign push      = (state_q == S_IDLE) ? (accept && enc_ok) : !fifo_full;
  assign push_word = (state_q == S_IDLE) ? enc_word
                                         : i_type(li_lo_q, li_rd_q, F3_ADD, li_rd_q, OPC_OP_IMM);
  assign pop       = out_valid && out_ready;
  assign out_valid = !fifo_empty;
  assign out_pc    = pc_q;
  assign err       = err_q;
  assign pc_d      = pop ? pc_q + 32'd4 : pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      li_rd_q <= '0;
      li_lo_q <= '0;
      err_q   <= 1'b0;
      pc_q    <= PC_RESET;
    end else begin
      err_q <= accept && !enc_ok;
      pc_q  <= pc_d;
      case (state_q)
        S_IDLE: begin
          if (accept && enc_ok && enc_li2) begin
            state_q <= S_LI_LO;
            li_rd_q <= req_rd;
            li_lo_q <= imm12;
          end
        end
        S_LI_LO: begin
          if (!fifo_full) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  enc_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .push_i (push),
    .data_i (push_word),
    .pop_i  (pop),
    .data_o (out_instr),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - Self-checking bench for instr_encoder with a behavioural encoding model.
module tb_instr_encoder;

  localparam logic [31:0] PC_RST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc;
  logic        err;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_pc;

  instr_encoder #(.DEPTH(4), .PC_RESET(PC_RST)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [31:0] imm12, input logic [31:0] rs1,
                                        input logic [31:0] f3, input logic [31:0] rd,
                                        input logic [31:0] opc);
    return imm12 * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + opc;
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm12, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3,
                                        input logic [31:0] opc);
    return (imm12 / 32) * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096
           + (imm12 % 32) * 128 + opc;
  endfunction

  function automatic void model(input logic [3:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, output bit ok, output int n,
                                output logic [31:0] w0, output logic [31:0] w1);
    logic [31:0] i12, hi;
    bit fits;
    i12  = imm % 4096;
    fits = ($signed(imm) >= -2048) && ($signed(imm) <= 2047);
    ok = 1; n = 1; w0 = 0; w1 = 0;
    case (op)
      4'd0:  w0 = 0;
      4'd1:  w0 = rs2 * 1048576 + rs1 * 32768 + rd * 128 + 32'h33;
      4'd2:  w0 = rs2 * 1048576 + rs1 * 32768 + 4 * 4096 + rd * 128 + 32'h33;
      4'd3:  begin ok = fits; w0 = enc_i(i12, rs1, 0, rd, 32'h13); end
      4'd4:  begin ok = fits; w0 = enc_i(i12, rs1, 6, rd, 32'h13); end
      4'd5:  begin ok = (imm < 32); w0 = enc_i(32 * 32 + imm % 32, rs1, 5, rd, 32'h13); end
      4'd6:  begin ok = fits; w0 = enc_i(i12, rs1, 0, rd, 32'h03); end
      4'd7:  begin ok = fits; w0 = enc_i(i12, rs1, 2, rd, 32'h03); end
      4'd8:  begin ok = fits; w0 = enc_s(i12, rs2, rs1, 0, 32'h23); end
      4'd9:  begin ok = fits; w0 = enc_s(i12, rs2, rs1, 2, 32'h23); end
      4'd10: begin ok = (i12 == 0); w0 = imm + rd * 128 + 32'h37; end
      4'd11: begin
        if (fits) w0 = enc_i(i12, 0, 0, rd, 32'h13);
        else begin
          hi = (imm + 32'd2048) / 4096;
          w0 = hi * 4096 + rd * 128 + 32'h37;
          if (i12 != 0) begin n = 2; w1 = enc_i(i12, rd, 0, rd, 32'h13); end
        end
      end
      default: ok = 0;
    endcase
    if (!ok) n = 0;
  endfunction

  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, output bit ok);
    req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
    req_valid = 1'b1; ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (req_ready) ok = 1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic pop_word(output logic [31:0] instr, output logic [31:0] pc, output bit got);
    got = 0; instr = '0; pc = '0; out_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      if (out_valid) begin instr = out_instr; pc = out_pc; got = 1; end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 0; req_op = 0; req_rd = 0; req_rs1 = 0; req_rs2 = 0;
    req_imm = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_pc = PC_RST;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    tests++; if (out_instr !== 32'h0) begin fails++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
    tests++; if (out_pc !== PC_RST) begin fails++; $display("FAIL reset_pc got=%h exp=%h", out_pc, PC_RST); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", err); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_add();
    bit ok;
    out_ready = 1'b1;
    send(4'd1, 5'd3, 5'd1, 5'd2, 32'd0, ok);
    tests++; if (!ok) begin fails++; $display("FAIL add_accept got=0 exp=1"); end
    tests++; if (out_valid !== 1'b1 || out_instr !== 32'h002081B3)
      begin fails++; $display("FAIL add_word got=%b/%h exp=1/002081b3", out_valid, out_instr); end
    tests++; if (out_pc !== exp_pc) begin fails++; $display("FAIL add_pc got=%h exp=%h", out_pc, exp_pc); end
    @(posedge clk); #1;
    exp_pc += 4;
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0 || out_pc !== exp_pc)
      begin fails++; $display("FAIL add_pop got=%b/%h exp=0/%h", out_valid, out_pc, exp_pc); end
  endtask

  task automatic test_li();
    bit ok, got;
    logic [31:0] w, pc;
    logic [31:0] exp_w [3] = '{32'h123462B7, 32'hFFF28293, 32'h123452B7};
    send(4'd11, 5'd5, 5'd0, 5'd0, 32'h12345FFF, ok);
    tests++; if (!ok || req_ready !== 1'b0)
      begin fails++; $display("FAIL li_lo_ready got=%b exp=0 (accepted=%0d)", req_ready, ok); end
    for (int k = 0; k < 2; k++) begin
      pop_word(w, pc, got);
      tests++; if (!got || w !== exp_w[k] || pc !== exp_pc)
        begin fails++; $display("FAIL li_word%0d got=%h@%h exp=%h@%h", k, w, pc, exp_w[k], exp_pc); end
      exp_pc += 4;
    end
    send(4'd11, 5'd5, 5'd0, 5'd0, 32'h12345000, ok);
    tests++; if (!ok || req_ready !== 1'b1)
      begin fails++; $display("FAIL li_single_ready got=%b exp=1", req_ready); end
    pop_word(w, pc, got);
    tests++; if (!got || w !== exp_w[2] || pc !== exp_pc)
      begin fails++; $display("FAIL li_single got=%h@%h exp=%h@%h", w, pc, exp_w[2], exp_pc); end
    exp_pc += 4;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL li_no_extra got=%b exp=0", out_valid); end
  endtask

  task automatic test_formats();
    bit ok, got;
    logic [31:0] w, pc;
    logic [3:0]  ops [3] = '{4'd9, 4'd5, 4'd3};
    logic [4:0]  rds [3] = '{5'd0, 5'd1, 5'd1};
    logic [4:0]  r1s [3] = '{5'd2, 5'd1, 5'd0};
    logic [4:0]  r2s [3] = '{5'd6, 5'd0, 5'd0};
    logic [31:0] ims [3] = '{32'd8, 32'd3, 32'hFFFFF800};
    logic [31:0] exps[3] = '{32'h00612423, 32'h4030D093, 32'h80000093};
    for (int k = 0; k < 3; k++) begin
      send(ops[k], rds[k], r1s[k], r2s[k], ims[k], ok);
      pop_word(w, pc, got);
      tests++; if (!ok || !got || w !== exps[k] || pc !== exp_pc)
        begin fails++; $display("FAIL fmt%0d got=%h@%h exp=%h@%h", k, w, pc, exps[k], exp_pc); end
      exp_pc += 4;
    end
  endtask

  task automatic test_reject();
    bit ok;
    logic [3:0]  ops [4] = '{4'd3, 4'd5, 4'd10, 4'd13};
    logic [31:0] ims [4] = '{32'd2048, 32'd32, 32'h1, 32'd0};
    for (int k = 0; k < 4; k++) begin
      send(ops[k], 5'd4, 5'd4, 5'd4, ims[k], ok);
      tests++; if (!ok || err !== 1'b1 || out_valid !== 1'b0)
        begin fails++; $display("FAIL reject%0d err/valid got=%b/%b exp=1/0", k, err, out_valid); end
      @(posedge clk); #1;
      tests++; if (err !== 1'b0 || out_pc !== exp_pc || out_valid !== 1'b0)
        begin fails++; $display("FAIL reject%0d after err/pc got=%b/%h exp=0/%h", k, err, out_pc, exp_pc); end
    end
  endtask

  task automatic test_full();
    bit ok, stalled;
    int n, acc_cycle;
    logic [31:0] words [5];
    logic [31:0] pcs [5];
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(4'd0, 5'd0, 5'd0, 5'd0, 32'd0, ok);
    tests++; if (req_ready !== 1'b0 || out_valid !== 1'b1)
      begin fails++; $display("FAIL full_ready got=%b exp=0", req_ready); end
    req_op = 4'd3; req_rd = 5'd7; req_rs1 = 5'd0; req_rs2 = 5'd0; req_imm = 32'd1;
    req_valid = 1'b1; stalled = 1;
    repeat (3) begin
      if (req_ready !== 1'b0) stalled = 0;
      @(posedge clk); #1;
    end
    tests++; if (!stalled) begin fails++; $display("FAIL full_stall got=ready exp=stall"); end
    out_ready = 1'b1; n = 0; acc_cycle = -1;
    for (int c = 0; c < 15 && n < 5; c++) begin
      bit fire;
      fire = req_valid && req_ready;
      if (fire) acc_cycle = c;
      if (out_valid) begin words[n] = out_instr; pcs[n] = out_pc; n++; end
      @(posedge clk); #1;
      if (fire) req_valid = 1'b0;
    end
    out_ready = 1'b0; req_valid = 1'b0;
    tests++; if (n != 5) begin fails++; $display("FAIL full_drain_count got=%0d exp=5", n); end
    for (int k = 0; k < n; k++) begin
      logic [31:0] ew;
      ew = (k == 4) ? 32'h00100393 : 32'h0;
      tests++; if (words[k] !== ew || pcs[k] !== exp_pc)
        begin fails++; $display("FAIL full_word%0d got=%h@%h exp=%h@%h", k, words[k], pcs[k], ew, exp_pc); end
      exp_pc += 4;
    end
    tests++; if (acc_cycle < 1) begin fails++; $display("FAIL full_accept_cycle got=%0d exp>=1", acc_cycle); end
  endtask

  task automatic test_reset_li();
    bit ok, seen;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(4'd0, 5'd0, 5'd0, 5'd0, 32'd0, ok);
    send(4'd11, 5'd9, 5'd0, 5'd0, 32'h12345FFF, ok);
    @(posedge clk); #1;
    tests++; if (!ok || req_ready !== 1'b0)
      begin fails++; $display("FAIL rli_stall got=%b exp=0", req_ready); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== PC_RST)
      begin fails++; $display("FAIL rli_async got=%b/%h/%h exp=0/0/%h", out_valid, out_instr, out_pc, PC_RST); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_pc = PC_RST;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rli_ready got=%b exp=1", req_ready); end
    out_ready = 1'b1; seen = 0;
    repeat (5) begin
      if (out_valid) seen = 1;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    tests++; if (seen || out_pc !== exp_pc)
      begin fails++; $display("FAIL rli_stale got=%0d/%h exp=0/%h", seen, out_pc, exp_pc); end
  endtask

  task automatic test_random();
    logic [31:0] sb [$];
    bit exp_err, fire_req, fire_out, ok;
    int n;
    logic [31:0] w0, w1;
    for (int c = 0; c < 1200; c++) begin
      tests++; if (err !== exp_err) begin fails++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, err, exp_err); end
      if (c < 1100 && !req_valid && $urandom_range(0, 2) != 0) begin
        req_op = 4'($urandom_range(0, 15));
        req_rd = 5'($urandom); req_rs1 = 5'($urandom); req_rs2 = 5'($urandom);
        case ($urandom_range(0, 4))
          0: req_imm = $urandom;
          1: req_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
          2: req_imm = 32'($urandom_range(0, 63));
          3: req_imm = $urandom & 32'hFFFFF000;
          default: req_imm = $urandom | 32'h0000_0FFF;
        endcase
        req_valid = 1'b1;
      end
      out_ready = $urandom_range(0, 1) != 0;
      #1;
      fire_req = req_valid && req_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL rnd_unexpected got=%h exp=none", out_instr);
        end else begin
          if (out_instr !== sb[0] || out_pc !== exp_pc) begin
            fails++; $display("FAIL rnd_word got=%h@%h exp=%h@%h", out_instr, out_pc, sb[0], exp_pc);
          end
          void'(sb.pop_front());
        end
        exp_pc += 4;
      end
      exp_err = 0;
      if (fire_req) begin
        model(req_op, req_rd, req_rs1, req_rs2, req_imm, ok, n, w0, w1);
        if (!ok) exp_err = 1;
        if (n >= 1) sb.push_back(w0);
        if (n == 2) sb.push_back(w1);
      end
      @(posedge clk); #1;
      if (fire_req) req_valid = 1'b0;
    end
    out_ready = 1'b0;
    tests++; if (sb.size() != 0 || out_valid !== 1'b0)
      begin fails++; $display("FAIL rnd_drain left=%0d valid=%b exp=0/0", sb.size(), out_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_li();
    test_formats();
    test_reject();
    test_full();
    test_reset_li();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
